// File: rtl/sw_dispatch_credit_ctrl_pkg.sv
// Shared constants and types for the Select/Wakeup dispatch admission controller.
package sw_dispatch_credit_ctrl_pkg;

  // Default RS sizes; these match the entry counts used by the RS allocators.
  localparam int unsigned ALU_ENT_NUM_DEF  = 8;
  localparam int unsigned LDST_ENT_NUM_DEF = 4;
  localparam int unsigned HOLD_TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } dp_state_e;

  // Credit counter width: enough to hold the larger RS entry count itself.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

  // Number of valid slots whose class flag matches (0..2).
  function automatic logic [1:0] slot_count(input logic v1, input logic c1,
                                            input logic v2, input logic c2);
    return {1'b0, v1 & c1} + {1'b0, v2 & c2};
  endfunction

endpackage

// File: rtl/sw_dispatch_credit_ctrl_if.sv
// Dispatch-side bundle between the decode slots, the RS issue feedback and
// the admission controller.
interface sw_dispatch_credit_ctrl_if #(
  parameter int unsigned CNT_W = 4
);
  logic             dp_valid_1_i;
  logic             dp_valid_2_i;
  logic             dp_is_mem_1_i;
  logic             dp_is_mem_2_i;
  logic             dp_stall_i;
  logic             kill_dp_i;
  logic             alu_issue_i;
  logic             mem_issue_i;
  logic [1:0]       alu_req_num_o;
  logic [1:0]       mem_req_num_o;
  logic             stall_dp_o;
  logic [CNT_W-1:0] alu_credit_o;
  logic [CNT_W-1:0] mem_credit_o;
  logic             deadlock_o;

  modport master (
    output dp_valid_1_i, dp_valid_2_i, dp_is_mem_1_i, dp_is_mem_2_i,
           dp_stall_i, kill_dp_i, alu_issue_i, mem_issue_i,
    input  alu_req_num_o, mem_req_num_o, stall_dp_o,
           alu_credit_o, mem_credit_o, deadlock_o
  );

  modport slave (
    input  dp_valid_1_i, dp_valid_2_i, dp_is_mem_1_i, dp_is_mem_2_i,
           dp_stall_i, kill_dp_i, alu_issue_i, mem_issue_i,
    output alu_req_num_o, mem_req_num_o, stall_dp_o,
           alu_credit_o, mem_credit_o, deadlock_o
  );
endinterface

// File: rtl/sw_credit_counter.sv
// Free-entry credit register for one reservation station.
module sw_credit_counter #(
  parameter int unsigned N     = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             reload_i,
  input  logic [1:0]       take_i,
  input  logic             give_i,
  output logic [CNT_W-1:0] credit_o
);

  // Reload to full on flush, otherwise net grants against issue returns.
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      credit_o <= CNT_W'(N);
    else if (reload_i)
      credit_o <= CNT_W'(N);
    else
      credit_o <= credit_o - CNT_W'(take_i) + CNT_W'(give_i);
  end

endmodule

// File: rtl/sw_dispatch_credit_ctrl.sv
// Dispatch admission controller: classifies the two dispatch slots, grants the
// pair all-or-nothing against registered RS credits, and sequences RUN/HOLD/FLUSH
// with a sticky deadlock flag for overly long holds.
module sw_dispatch_credit_ctrl
  import sw_dispatch_credit_ctrl_pkg::*;
#(
  parameter int unsigned ALU_ENT_NUM  = ALU_ENT_NUM_DEF,
  parameter int unsigned LDST_ENT_NUM = LDST_ENT_NUM_DEF,
  parameter int unsigned HOLD_TIMEOUT = HOLD_TIMEOUT_DEF,
  parameter int unsigned CNT_W        = cnt_width(ALU_ENT_NUM, LDST_ENT_NUM)
) (
  input logic                      clk_i,
  input logic                      reset_i,
  sw_dispatch_credit_ctrl_if.slave dp
);

  localparam int unsigned HC_W = $clog2(HOLD_TIMEOUT + 1);

  dp_state_e        state, state_next;
  logic [HC_W-1:0]  hold_cnt;
  logic [1:0]       need_alu, need_mem;
  logic [CNT_W-1:0] alu_credit, mem_credit;
  logic             fit, grant, stall, not_flush, reload;

  // Slot classification, fit check on registered credits, grant and stall.
  always_comb begin
    need_alu  = slot_count(dp.dp_valid_1_i, ~dp.dp_is_mem_1_i,
                           dp.dp_valid_2_i, ~dp.dp_is_mem_2_i);
    need_mem  = slot_count(dp.dp_valid_1_i, dp.dp_is_mem_1_i,
                           dp.dp_valid_2_i, dp.dp_is_mem_2_i);
    fit       = (CNT_W'(need_alu) <= alu_credit) && (CNT_W'(need_mem) <= mem_credit);
    not_flush = (state != ST_FLUSH);
    grant     = not_flush & ~dp.dp_stall_i & ~dp.kill_dp_i & fit & dp.dp_valid_1_i;
    stall     = dp.dp_valid_1_i & ~fit & not_flush & ~dp.kill_dp_i;
  end

  // Next-state selection; kill overrides every other transition.
  always_comb begin
    state_next = state;
    if (dp.kill_dp_i) begin
      state_next = ST_FLUSH;
    end else begin
      case (state)
        ST_RUN:   if (stall) state_next = ST_HOLD;
        ST_HOLD:  if (grant) state_next = ST_RUN;
        ST_FLUSH: state_next = ST_RUN;
        default:  state_next = ST_RUN;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) state <= ST_RUN;
    else          state <= state_next;
  end

  // Hold cycle counter: counts consecutive HOLD cycles, saturating, zero elsewhere.
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      hold_cnt <= '0;
    else if (state != ST_HOLD || state_next != ST_HOLD)
      hold_cnt <= '0;
    else if (hold_cnt != HC_W'(HOLD_TIMEOUT))
      hold_cnt <= hold_cnt + HC_W'(1);
  end

  // Sticky deadlock flag, set by the HOLD_TIMEOUT-th consecutive HOLD cycle.
  always_ff @(posedge clk_i) begin
    if (!reset_i)
      dp.deadlock_o <= 1'b0;
    else if (state == ST_HOLD && hold_cnt >= HC_W'(HOLD_TIMEOUT - 1))
      dp.deadlock_o <= 1'b1;
  end

  // Issue returns in the kill cycle and the FLUSH cycle are swallowed by the reload.
  assign reload = dp.kill_dp_i | (state == ST_FLUSH);

  assign dp.alu_req_num_o = grant ? need_alu : 2'd0;
  assign dp.mem_req_num_o = grant ? need_mem : 2'd0;
  assign dp.stall_dp_o    = stall;
  assign dp.alu_credit_o  = alu_credit;
  assign dp.mem_credit_o  = mem_credit;

  sw_credit_counter #(.N(ALU_ENT_NUM), .CNT_W(CNT_W)) u_alu_credit (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reload_i (reload),
    .take_i   (dp.alu_req_num_o),
    .give_i   (dp.alu_issue_i),
    .credit_o (alu_credit)
  );

  sw_credit_counter #(.N(LDST_ENT_NUM), .CNT_W(CNT_W)) u_mem_credit (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .reload_i (reload),
    .take_i   (dp.mem_req_num_o),
    .give_i   (dp.mem_issue_i),
    .credit_o (mem_credit)
  );

endmodule
